// File: rtl/xillylite_csr_pkg.sv
// Shared constants for the Xillybus-lite accelerator CSR bank: word offsets,
// CTRL/STATUS bit positions, channel stride and channel FSM state type.
package xillylite_csr_pkg;

   // Global registers, as word indices (byte address >> 2)
   localparam int unsigned REG_ID         = 0;
   localparam int unsigned REG_IRQ_STATUS = 1;
   localparam int unsigned REG_IRQ_ENABLE = 2;
   localparam int unsigned REG_BUSY       = 3;

   // Channel window: base 0x100, stride 0x20 (8 words)
   localparam int unsigned CH_BASE_WIDX   = 64;
   localparam int unsigned CH_STRIDE_W    = 8;

   // Word offsets inside a channel window
   localparam int unsigned CH_CTRL        = 0;
   localparam int unsigned CH_STATUS      = 1;
   localparam int unsigned CH_ARG0        = 2;
   localparam int unsigned CH_RESULT      = 6;
   localparam int unsigned CH_PERF        = 7;

   localparam int unsigned CTRL_START     = 0;
   localparam int unsigned CTRL_ABORT     = 1;

   localparam int unsigned STS_DONE       = 1;
   localparam int unsigned STS_TIMEOUT    = 2;
   localparam int unsigned STS_OVERRUN    = 3;

   localparam int unsigned ARG_N          = 4;
   localparam int unsigned ARG_W          = 32;
   localparam int unsigned CH_ARG_W       = ARG_N * ARG_W;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

endpackage

// File: rtl/xillylite_ch_ctrl.sv
// One accelerator channel: IDLE/RUN FSM, run timeout, sticky status,
// result capture and optional cycle counter (macro XLITE_PERF_CNT_EN).
// Ports: clk/rst_n; start_wr/abort_wr decoded CTRL writes; done/result from
// the accelerator; start_pulse/abort_pulse to the accelerator; busy, sts_*,
// result_q, perf for readback; irq_evt_c marks a completion or timeout edge.
module xillylite_ch_ctrl
   import xillylite_csr_pkg::*;
#(
   parameter int unsigned TIMEOUT_W = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_wr,
   input  logic        abort_wr,
   input  logic        done,
   input  logic [31:0] result,
   output logic        start_pulse,
   output logic        abort_pulse,
   output logic        busy,
   output logic        sts_done,
   output logic        sts_timeout,
   output logic        sts_overrun,
   output logic [31:0] result_q,
   output logic [31:0] perf,
   output logic        irq_evt_c
);

   // Counter is zeroed on start; firing when it steps onto all-ones means
   // 2^TIMEOUT_W-1 RUN cycles have elapsed.
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = ~(TIMEOUT_W'(1));

   ch_state_t            state, state_nxt;
   logic [TIMEOUT_W-1:0] tmo_cnt;
   logic                 tmo_hit;
   logic                 acc_start, fin_done, fin_abort, fin_tmo, ovr;

   assign tmo_hit = (tmo_cnt == TMO_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state; abort outranks start in IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_wr && !abort_wr) state_nxt = RUN;
         RUN:     if (done || abort_wr || tmo_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Event decode; priority in RUN is done > abort > timeout
   always_comb begin
      acc_start = 1'b0;
      fin_done  = 1'b0;
      fin_abort = 1'b0;
      fin_tmo   = 1'b0;
      ovr       = 1'b0;
      case (state)
         IDLE: acc_start = start_wr && !abort_wr;
         RUN: begin
            if (done)          fin_done  = 1'b1;
            else if (abort_wr) fin_abort = 1'b1;
            else if (tmo_hit)  fin_tmo   = 1'b1;
            ovr = start_wr && !abort_wr;
         end
         default: ;
      endcase
   end

   assign busy      = (state == RUN);
   assign irq_evt_c = fin_done || fin_tmo;

   // Pulses, timeout counter, sticky status and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_pulse <= 1'b0;
         abort_pulse <= 1'b0;
         tmo_cnt     <= '0;
         sts_done    <= 1'b0;
         sts_timeout <= 1'b0;
         sts_overrun <= 1'b0;
         result_q    <= '0;
      end else begin
         start_pulse <= acc_start;
         abort_pulse <= fin_abort || fin_tmo;
         if (acc_start) begin
            tmo_cnt     <= '0;
            sts_done    <= 1'b0;
            sts_timeout <= 1'b0;
            sts_overrun <= 1'b0;
         end else begin
            if (state == RUN) tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
            if (fin_done) begin
               sts_done <= 1'b1;
               result_q <= result;
            end
            if (fin_tmo) sts_timeout <= 1'b1;
            if (ovr)     sts_overrun <= 1'b1;
         end
      end
   end

`ifdef XLITE_PERF_CNT_EN
   // Saturating RUN-cycle counter, frozen outside RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           perf <= '0;
      else if (acc_start)                   perf <= '0;
      else if (state == RUN && perf != '1)  perf <= perf + 32'(1);
   end
`else
   assign perf = '0;
`endif

endmodule

// File: rtl/xillylite_accel_csr.sv
// N-channel CSR bank on the Xillybus-lite user interface.
// Ports: bus_clk/bus_rst_n; user_wren/wstrb/rden/addr/wr_data/rd_data/irq
// lite bus; ch_start/ch_abort pulses, ch_arg words, ch_done/ch_result from
// the accelerators. Optional per-channel PERF counter: XLITE_PERF_CNT_EN.
module xillylite_accel_csr
   import xillylite_csr_pkg::*;
#(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned TIMEOUT_W = 20,
   parameter logic [31:0] VERSION   = 32'h0001_0000
) (
   input  logic                       bus_clk,
   input  logic                       bus_rst_n,
   input  logic                       user_wren,
   input  logic [3:0]                 user_wstrb,
   input  logic                       user_rden,
   input  logic [31:0]                user_addr,
   input  logic [31:0]                user_wr_data,
   output logic [31:0]                user_rd_data,
   output logic                       user_irq,
   output logic [NUM_CH-1:0]          ch_start,
   output logic [NUM_CH-1:0]          ch_abort,
   output logic [NUM_CH*CH_ARG_W-1:0] ch_arg,
   input  logic [NUM_CH-1:0]          ch_done,
   input  logic [NUM_CH*32-1:0]       ch_result
);

   logic [9:0]        widx_c;
   logic [2:0]        ch_idx_c, reg_c;
   logic              ch_hit_c, glb_hit_c, ctrl_wr_c;
   logic [NUM_CH-1:0] start_wr_c, abort_wr_c, w1c_c;
   logic [ARG_N-1:0]  arg_wr_c [NUM_CH];
   logic [NUM_CH-1:0] irq_status, irq_enable, busy, irq_evt_c;
   logic [NUM_CH-1:0] sts_done, sts_timeout, sts_overrun;
   logic [31:0]       res_q [NUM_CH];
   logic [31:0]       perf  [NUM_CH];
   logic [31:0]       rd_c;
   logic              unused_addr_c;

   assign unused_addr_c = &{1'b0, user_addr[31:12], user_addr[1:0]};

   // Address decode on word index addr[11:2]
   assign widx_c    = user_addr[11:2];
   assign ch_idx_c  = widx_c[5:3];
   assign reg_c     = widx_c[2:0];
   assign glb_hit_c = (widx_c[9:2] == '0);
   assign ch_hit_c  = (widx_c[9:6] == 4'(CH_BASE_WIDX / (CH_STRIDE_W * 8))) &&
                      ({1'b0, ch_idx_c} < 4'(NUM_CH));
   assign ctrl_wr_c = user_wren && user_wstrb[0] && ch_hit_c && (reg_c == 3'(CH_CTRL));
   assign user_irq  = |(irq_status & irq_enable);

   always_comb begin
      start_wr_c = '0;
      abort_wr_c = '0;
      w1c_c      = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         arg_wr_c[c] = '0;
         if (ctrl_wr_c && ch_idx_c == 3'(c)) begin
            start_wr_c[c] = user_wr_data[CTRL_START];
            abort_wr_c[c] = user_wr_data[CTRL_ABORT];
         end
         for (int k = 0; k < ARG_N; k++)
            arg_wr_c[c][k] = user_wren && ch_hit_c && (ch_idx_c == 3'(c)) &&
                             (reg_c == 3'(CH_ARG0 + k));
      end
      if (user_wren && user_wstrb[0] && glb_hit_c && widx_c[1:0] == 2'(REG_IRQ_STATUS))
         w1c_c = user_wr_data[NUM_CH-1:0];
   end

   // Channel controllers
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      xillylite_ch_ctrl #(.TIMEOUT_W(TIMEOUT_W)) u_ch (
         .clk         (bus_clk),
         .rst_n       (bus_rst_n),
         .start_wr    (start_wr_c[c]),
         .abort_wr    (abort_wr_c[c]),
         .done        (ch_done[c]),
         .result      (ch_result[c*32 +: 32]),
         .start_pulse (ch_start[c]),
         .abort_pulse (ch_abort[c]),
         .busy        (busy[c]),
         .sts_done    (sts_done[c]),
         .sts_timeout (sts_timeout[c]),
         .sts_overrun (sts_overrun[c]),
         .result_q    (res_q[c]),
         .perf        (perf[c]),
         .irq_evt_c   (irq_evt_c[c])
      );
   end

   // Byte-enabled ARG storage, also driven straight onto ch_arg
   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         ch_arg <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < ARG_N; k++)
               for (int b = 0; b < 4; b++)
                  if (arg_wr_c[c][k] && user_wstrb[b])
                     ch_arg[c*CH_ARG_W + k*ARG_W + b*8 +: 8] <= user_wr_data[b*8 +: 8];
      end
   end

   // IRQ registers; a same-cycle set beats the W1C clear
   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         irq_status <= '0;
         irq_enable <= '0;
      end else begin
         irq_status <= (irq_status & ~w1c_c) | irq_evt_c;
         if (user_wren && user_wstrb[0] && glb_hit_c && widx_c[1:0] == 2'(REG_IRQ_ENABLE))
            irq_enable <= user_wr_data[NUM_CH-1:0];
      end
   end

   // Read mux
   always_comb begin
      rd_c = '0;
      if (glb_hit_c) begin
         case (widx_c[1:0])
            2'(REG_ID):         rd_c = VERSION;
            2'(REG_IRQ_STATUS): rd_c = 32'(irq_status);
            2'(REG_IRQ_ENABLE): rd_c = 32'(irq_enable);
            2'(REG_BUSY):       rd_c = 32'(busy);
            default:            rd_c = '0;
         endcase
      end else if (ch_hit_c) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx_c == 3'(c)) begin
               case (reg_c)
                  3'(CH_STATUS): begin
                     rd_c[STS_DONE]    = sts_done[c];
                     rd_c[STS_TIMEOUT] = sts_timeout[c];
                     rd_c[STS_OVERRUN] = sts_overrun[c];
                  end
                  3'(CH_RESULT): rd_c = res_q[c];
                  3'(CH_PERF):   rd_c = perf[c];
                  default:       ;
               endcase
               for (int k = 0; k < ARG_N; k++)
                  if (reg_c == 3'(CH_ARG0 + k))
                     rd_c = ch_arg[c*CH_ARG_W + k*ARG_W +: ARG_W];
            end
         end
      end
   end

   // Registered read data, held between reads
   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n)     user_rd_data <= '0;
      else if (user_rden) user_rd_data <= rd_c;
   end

endmodule

// File: tb/tb_xillylite_accel_csr.sv
// Directed self-checking bench for xillylite_accel_csr (NUM_CH=4, TIMEOUT_W=4).
module tb_xillylite_accel_csr;

   localparam int unsigned NUM_CH = 4;

   logic                  bus_clk = 1'b0;
   logic                  bus_rst_n;
   logic                  user_wren, user_rden;
   logic [3:0]            user_wstrb;
   logic [31:0]           user_addr, user_wr_data, user_rd_data;
   logic                  user_irq;
   logic [NUM_CH-1:0]     ch_start, ch_abort, ch_done;
   logic [NUM_CH*128-1:0] ch_arg;
   logic [NUM_CH*32-1:0]  ch_result;

   int vectors     = 0;
   int miscompares = 0;

   xillylite_accel_csr #(.NUM_CH(NUM_CH), .TIMEOUT_W(4), .VERSION(32'h0001_0000)) dut (
      .bus_clk      (bus_clk),
      .bus_rst_n    (bus_rst_n),
      .user_wren    (user_wren),
      .user_wstrb   (user_wstrb),
      .user_rden    (user_rden),
      .user_addr    (user_addr),
      .user_wr_data (user_wr_data),
      .user_rd_data (user_rd_data),
      .user_irq     (user_irq),
      .ch_start     (ch_start),
      .ch_abort     (ch_abort),
      .ch_arg       (ch_arg),
      .ch_done      (ch_done),
      .ch_result    (ch_result)
   );

   always #5 bus_clk = ~bus_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge bus_clk);
      user_wren = 1'b1; user_addr = a; user_wr_data = d; user_wstrb = s;
      @(negedge bus_clk);
      user_wren = 1'b0; user_wstrb = 4'h0;
   endtask

   task automatic rchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      @(negedge bus_clk);
      user_rden = 1'b1; user_addr = a;
      @(negedge bus_clk);
      user_rden = 1'b0;
      chk(tag, user_rd_data, exp);
   endtask

   initial begin
      logic [31:0] perf_exp;
      logic        seen;
`ifdef XLITE_PERF_CNT_EN
      perf_exp = 32'd10;
`else
      perf_exp = 32'd0;
`endif
      bus_rst_n = 1'b0; user_wren = 1'b0; user_rden = 1'b0; user_wstrb = 4'h0;
      user_addr = '0; user_wr_data = '0; ch_done = '0; ch_result = '0;
      repeat (3) @(negedge bus_clk);
      bus_rst_n = 1'b1;

      // Reset state
      chk("rst_start", 32'(ch_start), 32'h0);
      chk("rst_abort", 32'(ch_abort), 32'h0);
      chk("rst_arg",   32'(|ch_arg),  32'h0);
      chk("rst_irq",   32'(user_irq), 32'h0);
      chk("rst_rdata", user_rd_data,  32'h0);
      rchk("id", 32'h000, 32'h0001_0000);
      @(negedge bus_clk);
      chk("rd_hold", user_rd_data, 32'h0001_0000);
      rchk("unmapped", 32'h010, 32'h0);
      rchk("unmapped_ch4", 32'h180, 32'h0);
      rchk("busy_rst", 32'h00C, 32'h0);

      // Byte-enabled ARG write
      wr(32'h14C, 32'hDEAD_BEEF, 4'b0011);
      rchk("arg_lo", 32'h14C, 32'h0000_BEEF);
      chk("arg_port", ch_arg[2*128+32 +: 32], 32'h0000_BEEF);
      wr(32'h14C, 32'hCAFE_0000, 4'b1100);
      rchk("arg_hi", 32'h14C, 32'hCAFE_BEEF);
      wr(32'h000, 32'hFFFF_FFFF, 4'hF);
      rchk("id_ro", 32'h000, 32'h0001_0000);

      // Start ch0, done after 10 RUN cycles
      wr(32'h008, 32'h1, 4'hF);
      wr(32'h100, 32'h1, 4'hF);
      chk("ch0_start", 32'(ch_start), 32'h1);
      @(negedge bus_clk);
      chk("ch0_start_1cyc", 32'(ch_start), 32'h0);
      repeat (8) @(negedge bus_clk);
      ch_done[0] = 1'b1; ch_result[31:0] = 32'h1234;
      @(negedge bus_clk);
      ch_done[0] = 1'b0;
      chk("ch0_no_abort", 32'(ch_abort), 32'h0);
      chk("ch0_irq", 32'(user_irq), 32'h1);
      rchk("ch0_status", 32'h104, 32'h2);
      rchk("ch0_result", 32'h118, 32'h1234);
      rchk("ch0_perf",   32'h11C, perf_exp);
      rchk("ch0_ctrl_rd", 32'h100, 32'h0);
      rchk("irq_status0", 32'h004, 32'h1);
      wr(32'h004, 32'h1, 4'hF);
      chk("ch0_irq_clr", 32'(user_irq), 32'h0);

      // Timeout on ch1 after 15 RUN cycles
      wr(32'h120, 32'h1, 4'hF);
      chk("ch1_start", 32'(ch_start), 32'h2);
      rchk("ch1_busy", 32'h00C, 32'h2);
      repeat (12) @(negedge bus_clk);
      chk("ch1_abort_early", 32'(ch_abort), 32'h0);
      @(negedge bus_clk);
      chk("ch1_abort", 32'(ch_abort), 32'h2);
      rchk("ch1_status", 32'h124, 32'h4);
      rchk("ch1_irq_st", 32'h004, 32'h2);
      rchk("ch1_busy_end", 32'h00C, 32'h0);
      chk("ch1_irq_masked", 32'(user_irq), 32'h0);
      wr(32'h008, 32'h3, 4'hF);
      chk("ch1_irq_en", 32'(user_irq), 32'h1);
      wr(32'h004, 32'h2, 4'hF);
      wr(32'h008, 32'h1, 4'hF);

      // Back-to-back starts on ch3
      @(negedge bus_clk);
      user_wren = 1'b1; user_addr = 32'h160; user_wr_data = 32'h1; user_wstrb = 4'hF;
      @(negedge bus_clk);
      chk("ch3_start", 32'(ch_start), 32'h8);
      @(negedge bus_clk);
      user_wren = 1'b0; user_wstrb = 4'h0;
      chk("ch3_single", 32'(ch_start), 32'h0);
      rchk("ch3_overrun", 32'h164, 32'h8);
      rchk("ch3_busy", 32'h00C, 32'h8);

      // Abort write coinciding with ch_done: done wins
      @(negedge bus_clk);
      user_wren = 1'b1; user_addr = 32'h160; user_wr_data = 32'h2; user_wstrb = 4'hF;
      ch_done[3] = 1'b1; ch_result[96 +: 32] = 32'hA5A5;
      @(negedge bus_clk);
      user_wren = 1'b0; user_wstrb = 4'h0; ch_done[3] = 1'b0;
      chk("ch3_no_abort", 32'(ch_abort), 32'h0);
      @(negedge bus_clk);
      chk("ch3_no_abort2", 32'(ch_abort), 32'h0);
      rchk("ch3_status", 32'h164, 32'hA);
      rchk("ch3_result", 32'h178, 32'hA5A5);
      rchk("ch3_irq_st", 32'h004, 32'h8);
      wr(32'h004, 32'h8, 4'hF);

      // Restart clears sticky bits; abort issues a pulse but no IRQ
      wr(32'h160, 32'h1, 4'hF);
      rchk("ch3_sts_clr", 32'h164, 32'h0);
      wr(32'h160, 32'h2, 4'hF);
      chk("ch3_abort", 32'(ch_abort), 32'h8);
      rchk("ch3_abort_sts", 32'h164, 32'h0);
      rchk("ch3_abort_irq", 32'h004, 32'h0);
      wr(32'h160, 32'h3, 4'hF);
      chk("ch3_sa_nostart", 32'(ch_start), 32'h0);
      rchk("ch3_sa_busy", 32'h00C, 32'h0);

      // W1C clear coinciding with a set: set wins
      wr(32'h100, 32'h1, 4'hF);
      @(negedge bus_clk);
      user_wren = 1'b1; user_addr = 32'h004; user_wr_data = 32'h1; user_wstrb = 4'hF;
      ch_done[0] = 1'b1; ch_result[31:0] = 32'h55;
      @(negedge bus_clk);
      user_wren = 1'b0; user_wstrb = 4'h0; ch_done[0] = 1'b0;
      rchk("w1c_set_wins", 32'h004, 32'h1);
      chk("w1c_irq", 32'(user_irq), 32'h1);
      wr(32'h004, 32'h1, 4'hF);

      // ch_done while IDLE is ignored
      @(negedge bus_clk);
      ch_done[0] = 1'b1; ch_result[31:0] = 32'hFFFF;
      @(negedge bus_clk);
      ch_done[0] = 1'b0;
      rchk("idle_done_res", 32'h118, 32'h55);
      rchk("idle_done_irq", 32'h004, 32'h0);

      // Reset while ch0 is running
      wr(32'h100, 32'h1, 4'hF);
      repeat (3) @(negedge bus_clk);
      bus_rst_n = 1'b0;
      repeat (2) @(negedge bus_clk);
      bus_rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge bus_clk);
         seen = seen | (|ch_start) | (|ch_abort);
      end
      chk("rstrun_pulses", 32'(seen), 32'h0);
      rchk("rstrun_busy", 32'h00C, 32'h0);
      rchk("rstrun_status", 32'h104, 32'h0);
      rchk("rstrun_result", 32'h118, 32'h0);
      chk("rstrun_arg", 32'(|ch_arg), 32'h0);
      chk("rstrun_irq", 32'(user_irq), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
